encoder_ctrl: RTL

Block sequencer for the 8-bit parallel RSC constituent encoder, one byte per cycle. It accepts a start request with a block-size select and takes the code block over a valid/ready byte stream. It clears the encoder state, drives the encoder's ck/enable per accepted byte, and registers the systematic and parity bytes onto a backpressured output stream. It then emits one tail beat and signals done; it sits between the input byte buffer and the interleaver/rate-matching stage.

---
 rtl/encoder_pkg.sv | 16 +
 rtl/encoder_out_reg.sv | 46 ++++
 rtl/encoder_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and block-size constants for the RSC encoder sequencer
package encoder_pkg;

  localparam int K_SMALL_BYTES = 132;
  localparam int K_LARGE_BYTES = 768;
  localparam int CNT_W         = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    DATA,
    TAIL,
    FLUSH
  } state_t;

endpackage

// File: rtl/encoder_out_reg.sv
// rtl/encoder_out_reg.sv - one-deep valid/ready holding register for data and tail beats
module encoder_out_reg (
  input  logic       clk,
  input  logic       aclr,
  input  logic       load_data,
  input  logic       load_tail,
  input  logic [7:0] xk,
  input  logic [7:0] zk,
  input  logic       last,
  input  logic [2:0] tail,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_xk,
  output logic [7:0] out_zk,
  output logic       out_last,
  output logic       out_tail_valid,
  output logic [2:0] out_tail
);

  // A tail load retires any pending data beat, so data and tail never coexist.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      out_valid      <= 1'b0;
      out_xk         <= 8'h00;
      out_zk         <= 8'h00;
      out_last       <= 1'b0;
      out_tail_valid <= 1'b0;
      out_tail       <= 3'b000;
    end else if (load_data) begin
      out_valid <= 1'b1;
      out_xk    <= xk;
      out_zk    <= zk;
      out_last  <= last;
    end else if (load_tail) begin
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_tail_valid <= 1'b1;
      out_tail       <= tail;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_tail_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/encoder_ctrl.sv
// rtl/encoder_ctrl.sv - block sequencer driving the byte-parallel RSC encoder
module encoder_ctrl
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic             k_sel,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic [7:0]       enc_ck,
  output logic             enc_en,
  output logic             enc_clr,
  input  logic [7:0]       enc_xk,
  input  logic [7:0]       enc_zk,
  input  logic [2:0]       enc_tail,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_xk,
  output logic [7:0]       out_zk,
  output logic             out_last,
  output logic             out_tail_valid,
  output logic [2:0]       out_tail,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] byte_cnt
);

  state_t           state;
  logic             k_lat;
  logic [CNT_W-1:0] kbytes_m1;
  logic             slot_free;
  logic             fire;
  logic             last_fire;
  logic             load_tail;

  assign kbytes_m1 = k_lat ? CNT_W'(K_LARGE_BYTES - 1) : CNT_W'(K_SMALL_BYTES - 1);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && slot_free;
  assign fire      = in_valid && in_ready;
  assign last_fire = fire && (byte_cnt == kbytes_m1);
  assign load_tail = (state == TAIL) && slot_free;

  // The encoder only sees a byte on the cycle it is consumed; otherwise its state holds.
  assign enc_en = fire;
  assign enc_ck = fire ? in_byte : 8'h00;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state    <= IDLE;
      k_lat    <= 1'b0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      enc_clr  <= 1'b0;
    end else begin
      done    <= 1'b0;
      enc_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            k_lat   <= k_sel;
            busy    <= 1'b1;
            enc_clr <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          byte_cnt <= '0;
          state    <= DATA;
        end
        DATA: begin
          if (fire) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (last_fire) state <= TAIL;
          end
        end
        TAIL: begin
          if (load_tail) state <= FLUSH;
        end
        FLUSH: begin
          if (out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  encoder_out_reg u_out_reg (
    .clk            (clk),
    .aclr           (aclr),
    .load_data      (fire),
    .load_tail      (load_tail),
    .xk             (enc_xk),
    .zk             (enc_zk),
    .last           (last_fire),
    .tail           (enc_tail),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_xk         (out_xk),
    .out_zk         (out_zk),
    .out_last       (out_last),
    .out_tail_valid (out_tail_valid),
    .out_tail       (out_tail)
  );

endmodule
